// File: rtl/mux_nto1_scan.sv
// Registered N:1 bit multiplexer with a direct-select mode and a windowed scan mode.
// Optional early stop on the first set bit of the scan: define MUX_FIRST_HIT_EN.
module mux_nto1_scan #(
  parameter int N_IN  = 256,
  parameter int SEL_W = $clog2(N_IN)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_IN-1:0]   in,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              sel_valid,
  input  logic [SEL_W-1:0]  scan_first,
  input  logic [SEL_W-1:0]  scan_last,
  input  logic              start,
  output logic              out,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic [SEL_W:0]    hit_count
`ifdef MUX_FIRST_HIT_EN
  ,
  output logic [SEL_W-1:0]  first_hit_idx,
  output logic              hit_found
`endif
);

  // Handshake: sel_valid and start are single-cycle request strobes with no ready;
  // they are honoured only in IDLE and silently dropped otherwise. out_valid marks
  // every cycle in which out/out_sel carry a fresh sample; there is no back-pressure.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SEL_W:0]   N_EXT    = (SEL_W+1)'(N_IN);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_IN - 1);

  state_t           state;
  logic [SEL_W-1:0] cnt;
  logic [SEL_W-1:0] last_q;
  logic             cur_bit;
  logic             dir_bit;
  logic             stop_on_hit;

  // Indices past N_IN-1 exist only when N_IN is not a power of two; they read as 0.
  function automatic logic pick(input logic [N_IN-1:0] v, input logic [SEL_W-1:0] idx);
    if ({1'b0, idx} < N_EXT) return v[idx];
    else return 1'b0;
  endfunction

  function automatic logic [SEL_W-1:0] clamp(input logic [SEL_W-1:0] idx);
    if ({1'b0, idx} >= N_EXT) return LAST_IDX;
    else return idx;
  endfunction

  assign cur_bit = pick(in, cnt);
  assign dir_bit = pick(in, sel);

`ifdef MUX_FIRST_HIT_EN
  assign stop_on_hit = cur_bit;
`else
  assign stop_on_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_q    <= '0;
      out       <= 1'b0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      hit_count <= '0;
`ifdef MUX_FIRST_HIT_EN
      first_hit_idx <= '0;
      hit_found     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          out_valid <= 1'b0;
          if (mode) begin
            if (start) begin
              cnt       <= clamp(scan_first);
              last_q    <= clamp(scan_last);
              hit_count <= '0;
              busy      <= 1'b1;
              state     <= SCAN;
`ifdef MUX_FIRST_HIT_EN
              first_hit_idx <= clamp(scan_first);
              hit_found     <= 1'b0;
`endif
            end
          end else if (sel_valid) begin
            out       <= dir_bit;
            out_sel   <= sel;
            out_valid <= 1'b1;
          end
        end

        SCAN: begin
          // in is read live each beat, so a changing vector is seen as it changes.
          out       <= cur_bit;
          out_sel   <= cnt;
          out_valid <= 1'b1;
          hit_count <= hit_count + (SEL_W+1)'(cur_bit);
`ifdef MUX_FIRST_HIT_EN
          if (cur_bit) begin
            first_hit_idx <= cnt;
            hit_found     <= 1'b1;
          end
`endif
          if (cnt == last_q || stop_on_hit) begin
            busy  <= 1'b0;
            state <= DONE;
          end else if (cnt == LAST_IDX) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          out_valid <= 1'b0;
          done      <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
